// File: rtl/matrix_pkg.sv
// ============================================================================
// Module      : matrix_pkg
// Description : Shared types and constants for the HT1632-style matrix bus
//               writer: request modes, frame ID codes, FSM states and a
//               frame-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_pkg;

    typedef enum logic {
        MODE_CMD   = 1'b0,
        MODE_WRITE = 1'b1
    } mode_t;

    localparam logic [2:0] ID_CMD   = 3'b100;
    localparam logic [2:0] ID_WRITE = 3'b101;

    // COMMAND frame: ID + 8-bit code + trailing don't-care bit.
    localparam int CMD_BITS       = 12;
    // WRITE frame header: ID + 7-bit RAM address, payload follows.
    localparam int WRITE_HDR_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_SETUP   = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_HOLD    = 3'd4,
        ST_RELEASE = 3'd5
    } state_t;

    function automatic int frame_len(input mode_t mode, input int data_bits);
        return (mode == MODE_WRITE) ? WRITE_HDR_BITS + data_bits : CMD_BITS;
    endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_bit_timer.sv
// ============================================================================
// Module      : matrix_bit_timer
// Description : Half-bit divider for the matrix bus. Counts HALF_DIV clocks
//               per half period and flips phase at each wrap.
// Revision    : 1.0 - initial release
// Ports       : clk, reset (sync, active-low), restart (zero the timer),
//               phase (0 = low half, 1 = high half), bit_start (first cycle
//               of a bit), half_end (last cycle of the low half), bit_end
//               (last cycle of a bit).
// ============================================================================
`default_nettype none

module matrix_bit_timer #(
    parameter int HALF_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic phase,
    output logic bit_start,
    output logic half_end,
    output logic bit_end
);

    localparam int HCNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [HCNT_W-1:0] C_LAST = HCNT_W'(HALF_DIV - 1);

    logic [HCNT_W-1:0] r_cnt;
    logic              r_phase;
    logic              w_last;

    assign w_last    = (r_cnt == C_LAST);
    assign phase     = r_phase;
    assign bit_start = !r_phase && (r_cnt == '0);
    assign half_end  = !r_phase && w_last;
    assign bit_end   = r_phase && w_last;

    always_ff @(posedge clk) begin
        if (!reset || restart) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_last) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/matrix_bus_writer.sv
// ============================================================================
// Module      : matrix_bus_writer
// Description : Serialises COMMAND / WRITE transactions onto a 3-wire
//               HT1632-style bus (per-chip cs_n, wr_n, data) for NUM_CHIPS
//               cascaded controllers. One request at a time over valid/ready.
// Revision    : 1.0 - initial release
// Option      : MATRIX_BROADCAST_EN - chip index all-ones selects every chip.
// Ports       : clk, reset (sync, active-low)
//               req_valid/req_ready handshake; req_mode (0 CMD, 1 WRITE),
//               req_chip, req_addr, req_cmd, req_data request fields
//               cs_n, wr_n, data bus outputs; busy; err (reject pulse)
// ============================================================================
`default_nettype none

module matrix_bus_writer #(
    parameter int NUM_CHIPS = 4,
    parameter int DATA_BITS = 4,
    parameter int HALF_DIV  = 16,
    parameter int CHIP_W    = $clog2(NUM_CHIPS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_mode,
    input  logic [CHIP_W-1:0]    req_chip,
    input  logic [6:0]           req_addr,
    input  logic [7:0]           req_cmd,
    input  logic [DATA_BITS-1:0] req_data,
    output logic [NUM_CHIPS-1:0] cs_n,
    output logic                 wr_n,
    output logic                 data,
    output logic                 busy,
    output logic                 err
);

    import matrix_pkg::*;

    localparam int FRAME_W = (WRITE_HDR_BITS + DATA_BITS > CMD_BITS) ?
                             (WRITE_HDR_BITS + DATA_BITS) : CMD_BITS;
    localparam int CNT_W   = $clog2(FRAME_W);

    state_t                r_state;
    logic [FRAME_W-1:0]    r_shift;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [NUM_CHIPS-1:0]  r_cs_sel;
    logic                  r_bad;

    logic [FRAME_W-1:0]    w_frame;
    logic [CNT_W-1:0]      w_nbits_m1;
    logic [NUM_CHIPS-1:0]  w_cs_sel;
    logic                  w_bcast;
    logic                  w_chip_bad;
    logic                  w_phase;
    logic                  w_bit_start;
    logic                  w_half_end;
    logic                  w_bit_end;
    logic                  w_unused;

    // Timer is zeroed on the cycle before SETUP so every frame starts on
    // the same phase.
    matrix_bit_timer #(
        .HALF_DIV (HALF_DIV)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .restart   (r_state == ST_CHECK),
        .phase     (w_phase),
        .bit_start (w_bit_start),
        .half_end  (w_half_end),
        .bit_end   (w_bit_end)
    );

    // Phase and bit_start are not needed: outputs are registered on the
    // edges flagged by half_end / bit_end.
    assign w_unused = &{1'b0, w_phase, w_bit_start};

    // Frame left-aligned so the bit to send is always the MSB.
    always_comb begin
        w_frame = '0;
        if (mode_t'(req_mode) == MODE_WRITE) begin
            w_frame[FRAME_W-1 -: WRITE_HDR_BITS + DATA_BITS] = {ID_WRITE, req_addr, req_data};
        end else begin
            w_frame[FRAME_W-1 -: CMD_BITS] = {ID_CMD, req_cmd, 1'b0};
        end
        w_nbits_m1 = CNT_W'(frame_len(mode_t'(req_mode), DATA_BITS) - 1);
    end

    always_comb begin
        w_bcast = 1'b0;
`ifdef MATRIX_BROADCAST_EN
        w_bcast = (req_chip == {CHIP_W{1'b1}});
`endif
        w_chip_bad = !w_bcast && (int'(req_chip) >= NUM_CHIPS);
        w_cs_sel   = '1;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            w_cs_sel[i] = ~(w_bcast | (int'(req_chip) == i));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_cs_sel  <= '1;
            r_bad     <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            cs_n      <= '1;
            wr_n      <= 1'b1;
            data      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_shift   <= w_frame;
                        r_bit_cnt <= w_nbits_m1;
                        r_cs_sel  <= w_cs_sel;
                        r_bad     <= w_chip_bad;
                        err       <= w_chip_bad;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= ST_CHECK;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                // One decision cycle: rejected requests return without
                // touching the bus, valid ones select their chip(s).
                ST_CHECK: begin
                    if (r_bad) begin
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        cs_n    <= r_cs_sel;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_bit_end) begin
                        wr_n    <= 1'b0;
                        data    <= r_shift[FRAME_W-1];
                        r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_half_end) begin
                        wr_n <= 1'b1;
                    end
                    if (w_bit_end) begin
                        if (r_bit_cnt == '0) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                            wr_n      <= 1'b0;
                            data      <= r_shift[FRAME_W-1];
                            r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_bit_end) begin
                        cs_n    <= '1;
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (w_bit_end) begin
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
